ps2_console_ctrl: RTL and testbench

- Sits between the PS/2 receiver (byte + valid strobe) and the write port of the 80x30 VGA text RAM in the keyboard demo.
- Decodes set-2 make/break sequences and tracks shift state.
- Translates keys to ASCII, manages the cursor, and issues single-byte RAM writes under a grant handshake, because the RAM port is shared with the VGA refresh/loader.

---
 rtl/ps2_console_if.sv | 26 ++
 rtl/ps2_console_ctrl.sv | 136 +++++++++++++
 tb/tb_ps2_console_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_console_if.sv
// ps2_console_if: scancode input, shared text-RAM write port and status for ps2_console_ctrl.
// caps_lock is present only when CAPS_LOCK_EN is defined.
interface ps2_console_if #(parameter int ADDR_W = 12);
   logic [7:0]        scancode;
   logic              scancode_valid;
   logic              ram_grant;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic [4:0]        cursor_row;
   logic [6:0]        cursor_col;
   logic              busy;
   logic              overrun;
`ifdef CAPS_LOCK_EN
   logic              caps_lock;
   modport master (input scancode, scancode_valid, ram_grant,
                   output ram_we, ram_addr, ram_wdata, cursor_row, cursor_col, busy, overrun, caps_lock);
   modport slave (output scancode, scancode_valid, ram_grant,
                  input ram_we, ram_addr, ram_wdata, cursor_row, cursor_col, busy, overrun, caps_lock);
`else
   modport master (input scancode, scancode_valid, ram_grant,
                   output ram_we, ram_addr, ram_wdata, cursor_row, cursor_col, busy, overrun);
   modport slave (output scancode, scancode_valid, ram_grant,
                  input ram_we, ram_addr, ram_wdata, cursor_row, cursor_col, busy, overrun);
`endif
endinterface

// File: rtl/ps2_console_ctrl.sv
// ps2_console_ctrl: set-2 scancodes to ASCII writes into the COLSxROWS text RAM, with cursor and shift tracking.
// Optional macro CAPS_LOCK_EN adds a caps lock toggle on make code 58 and the caps_lock output.
module ps2_console_ctrl #(
   parameter int COLS   = 80,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 12
) (
   input logic           clk,
   input logic           rst_n,
   ps2_console_if.master bus
);
   typedef enum logic [1:0] {IDLE, BREAK, WRITE, ERASE} state_e;
   state_e            state_q;
   logic              shift_q, we_q, overrun_q, upper, at_home, last_col, busy;
   logic [4:0]        row_q, row_inc, row_bs;
   logic [6:0]        col_q, col_inc, col_bs;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q;
   logic [8:0]        key;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] r, input logic [6:0] c);
      return ADDR_W'(int'(r) * COLS + int'(c));
   endfunction

   // Returns {mapped, ascii}; letters take case from up, digits/symbols from sh.
   function automatic logic [8:0] keymap(input logic [7:0] c, input logic up, input logic sh);
      logic [7:0] l;
      logic [8:0] k;
      case (c)
         8'h1C: l = "a";  8'h32: l = "b";  8'h21: l = "c";  8'h23: l = "d";  8'h24: l = "e";
         8'h2B: l = "f";  8'h34: l = "g";  8'h33: l = "h";  8'h43: l = "i";  8'h3B: l = "j";
         8'h42: l = "k";  8'h4B: l = "l";  8'h3A: l = "m";  8'h31: l = "n";  8'h44: l = "o";
         8'h4D: l = "p";  8'h15: l = "q";  8'h2D: l = "r";  8'h1B: l = "s";  8'h2C: l = "t";
         8'h3C: l = "u";  8'h2A: l = "v";  8'h1D: l = "w";  8'h22: l = "x";  8'h35: l = "y";
         8'h1A: l = "z";
         default: l = 8'h00;
      endcase
      case (c)
         8'h16: k = {1'b1, sh ? "!" : "1"};
         8'h1E: k = {1'b1, sh ? "@" : "2"};
         8'h26: k = {1'b1, sh ? "#" : "3"};
         8'h25: k = {1'b1, sh ? "$" : "4"};
         8'h2E: k = {1'b1, sh ? "%" : "5"};
         8'h36: k = {1'b1, sh ? "^" : "6"};
         8'h3D: k = {1'b1, sh ? "&" : "7"};
         8'h3E: k = {1'b1, sh ? "*" : "8"};
         8'h46: k = {1'b1, sh ? "(" : "9"};
         8'h45: k = {1'b1, sh ? ")" : "0"};
         8'h29: k = 9'h120;
         default: k = 9'h000;
      endcase
      if (l != 8'h00) k = {1'b1, up ? l - 8'h20 : l};
      return k;
   endfunction

   assign last_col = col_q == 7'(COLS - 1);
   assign at_home  = row_q == 5'd0 && col_q == 7'd0;
   assign row_inc  = row_q == 5'(ROWS - 1) ? 5'd0 : row_q + 5'd1;
   assign col_inc  = last_col ? 7'd0 : col_q + 7'd1;
   assign col_bs   = col_q == 7'd0 ? 7'(COLS - 1) : col_q - 7'd1;
   assign row_bs   = col_q == 7'd0 ? row_q - 5'd1 : row_q;
   assign busy     = state_q == WRITE || state_q == ERASE;
`ifdef CAPS_LOCK_EN
   logic caps_q;
   assign upper         = shift_q ^ caps_q;
   assign bus.caps_lock = caps_q;
`else
   assign upper = shift_q;
`endif
   assign key = keymap(bus.scancode, upper, shift_q);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= 1'b0;
         row_q     <= 5'd0;
         col_q     <= 7'd0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 8'h00;
         overrun_q <= 1'b0;
`ifdef CAPS_LOCK_EN
         caps_q    <= 1'b0;
`endif
      end else begin
         overrun_q <= bus.scancode_valid && busy;
         case (state_q)
            IDLE: if (bus.scancode_valid) begin
               if (bus.scancode == 8'hF0) state_q <= BREAK;
               else if (bus.scancode == 8'h12 || bus.scancode == 8'h59) shift_q <= 1'b1;
               else if (bus.scancode == 8'h66) begin
                  if (!at_home) begin
                     row_q   <= row_bs;
                     col_q   <= col_bs;
                     addr_q  <= addr_of(row_bs, col_bs);
                     wdata_q <= 8'h20;
                     we_q    <= 1'b1;
                     state_q <= ERASE;
                  end
               end else if (bus.scancode == 8'h5A) begin
                  row_q <= row_inc;
                  col_q <= 7'd0;
`ifdef CAPS_LOCK_EN
               end else if (bus.scancode == 8'h58) begin
                  caps_q <= !caps_q;
`endif
               end else if (key[8]) begin
                  addr_q  <= addr_of(row_q, col_q);
                  wdata_q <= key[7:0];
                  we_q    <= 1'b1;
                  state_q <= WRITE;
               end
            end
            BREAK: if (bus.scancode_valid) begin
               if (bus.scancode == 8'h12 || bus.scancode == 8'h59) shift_q <= 1'b0;
               state_q <= IDLE;
            end
            default: if (bus.ram_grant) begin
               we_q    <= 1'b0;
               state_q <= IDLE;
               if (state_q == WRITE) begin
                  col_q <= col_inc;
                  if (last_col) row_q <= row_inc;
               end
            end
         endcase
      end

   assign bus.ram_we     = we_q;
   assign bus.ram_addr   = addr_q;
   assign bus.ram_wdata  = wdata_q;
   assign bus.cursor_row = row_q;
   assign bus.cursor_col = col_q;
   assign bus.busy       = busy;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_ps2_console_ctrl.sv
// tb_ps2_console_ctrl: vector table, directed corner sequences and random traffic against a
// linear-cursor reference model of ps2_console_ctrl.
module tb_ps2_console_ctrl;
   localparam int COLS = 80, ROWS = 30, N = COLS * ROWS;
   logic clk = 1'b0, rst_n = 1'b0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

   ps2_console_if #(.ADDR_W(12)) bus ();
   ps2_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

   // Reference model: cursor as a linear position, one optional pending write.
   bit m_brk, m_shift, m_caps, m_pend, m_adv, m_ov;
   int m_lin, m_addr, m_data;
   byte unsigned letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
      8'h1D, 8'h22, 8'h35, 8'h1A};
   byte unsigned digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
   string digits = "1234567890", symbols = "!@#$%^&*()";
   byte unsigned pool [16] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h16, 8'h45, 8'h29, 8'h12, 8'h59,
      8'hF0, 8'h66, 8'h5A, 8'h58, 8'h76, 8'h00, 8'h3E};

   function automatic int lookup(input logic [7:0] c);
      for (int i = 0; i < 26; i++)
         if (letter_codes[i] == c) return ((m_shift ^ m_caps) ? 65 : 97) + i;
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == c) return m_shift ? int'(symbols[i]) : int'(digits[i]);
      return c == 8'h29 ? 32 : -1;
   endfunction

   task automatic model_reset();
      m_brk = 0; m_shift = 0; m_caps = 0; m_pend = 0; m_adv = 0; m_ov = 0; m_lin = 0; m_addr = 0; m_data = 0;
   endtask

   task automatic model_edge(input bit v, input logic [7:0] c, input bit g);
      int ch;
      m_ov = v && m_pend;
      if (m_pend) begin
         if (g) begin
            m_pend = 0;
            if (m_adv) m_lin = (m_lin + 1) % N;
         end
      end else if (v) begin
         if (m_brk) begin
            if (c == 8'h12 || c == 8'h59) m_shift = 0;
            m_brk = 0;
         end else if (c == 8'hF0) m_brk = 1;
         else if (c == 8'h12 || c == 8'h59) m_shift = 1;
         else if (c == 8'h66) begin
            if (m_lin > 0) begin
               m_lin--;
               m_pend = 1; m_adv = 0; m_addr = m_lin; m_data = 32;
            end
         end else if (c == 8'h5A) m_lin = ((m_lin / COLS + 1) % ROWS) * COLS;
`ifdef CAPS_LOCK_EN
         else if (c == 8'h58) m_caps = !m_caps;
`endif
         else begin
            ch = lookup(c);
            if (ch >= 0) begin
               m_pend = 1; m_adv = 1; m_addr = m_lin; m_data = ch;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, " we"}, int'(bus.ram_we), int'(m_pend));
      chk({tag, " busy"}, int'(bus.busy), int'(m_pend));
      chk({tag, " overrun"}, int'(bus.overrun), int'(m_ov));
      chk({tag, " row"}, int'(bus.cursor_row), m_lin / COLS);
      chk({tag, " col"}, int'(bus.cursor_col), m_lin % COLS);
      if (m_pend) begin
         chk({tag, " addr"}, int'(bus.ram_addr), m_addr);
         chk({tag, " wdata"}, int'(bus.ram_wdata), m_data);
      end
`ifdef CAPS_LOCK_EN
      chk({tag, " caps"}, int'(bus.caps_lock), int'(m_caps));
`endif
   endtask

   task automatic cyc(input bit v, input logic [7:0] c, input bit g);
      bus.scancode_valid = v;
      bus.scancode = c;
      bus.ram_grant = g;
      @(posedge clk);
      #1;
      model_edge(v, c, g);
   endtask

   typedef struct {
      bit v; logic [7:0] c; bit g;
      bit we; int addr; int wd; int row; int col; bit ov;
   } vec_t;
   vec_t tbl [27];

   initial begin
      tbl = '{
         '{1, 8'h1C, 1, 1, 0, 8'h61, 0, 0, 0}, '{0, 8'h00, 1, 0, 0, 0, 0, 1, 0},
         '{1, 8'hF0, 1, 0, 0, 0, 0, 1, 0},     '{1, 8'h1C, 1, 0, 0, 0, 0, 1, 0},
         '{1, 8'h12, 1, 0, 0, 0, 0, 1, 0},     '{1, 8'h1C, 1, 1, 1, 8'h41, 0, 1, 0},
         '{0, 8'h00, 1, 0, 0, 0, 0, 2, 0},     '{1, 8'hF0, 1, 0, 0, 0, 0, 2, 0},
         '{1, 8'h12, 1, 0, 0, 0, 0, 2, 0},     '{1, 8'h32, 1, 1, 2, 8'h62, 0, 2, 0},
         '{0, 8'h00, 1, 0, 0, 0, 0, 3, 0},     '{1, 8'h66, 1, 1, 2, 8'h20, 0, 2, 0},
         '{0, 8'h00, 1, 0, 0, 0, 0, 2, 0},     '{1, 8'h66, 1, 1, 1, 8'h20, 0, 1, 0},
         '{0, 8'h00, 1, 0, 0, 0, 0, 1, 0},     '{1, 8'h66, 1, 1, 0, 8'h20, 0, 0, 0},
         '{0, 8'h00, 1, 0, 0, 0, 0, 0, 0},     '{1, 8'h66, 1, 0, 0, 0, 0, 0, 0},
         '{1, 8'h16, 1, 1, 0, 8'h31, 0, 0, 0}, '{0, 8'h00, 1, 0, 0, 0, 0, 1, 0},
         '{1, 8'h5A, 1, 0, 0, 0, 1, 0, 0},     '{1, 8'h29, 1, 1, 80, 8'h20, 1, 0, 0},
         '{0, 8'h00, 1, 0, 0, 0, 1, 1, 0},     '{1, 8'h76, 1, 0, 0, 0, 1, 1, 0},
         '{1, 8'h1C, 0, 1, 81, 8'h61, 1, 1, 0}, '{1, 8'h32, 0, 1, 81, 8'h61, 1, 1, 1},
         '{0, 8'h00, 1, 0, 0, 0, 1, 2, 0}};
      bus.scancode_valid = 1'b0;
      bus.scancode = 8'h00;
      bus.ram_grant = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset we", int'(bus.ram_we), 0);
      chk("reset addr", int'(bus.ram_addr), 0);
      chk("reset wdata", int'(bus.ram_wdata), 0);
      chk("reset row", int'(bus.cursor_row), 0);
      chk("reset col", int'(bus.cursor_col), 0);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset overrun", int'(bus.overrun), 0);
      @(negedge clk) rst_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].v, tbl[i].c, tbl[i].g);
         chk($sformatf("vec%0d we", i), int'(bus.ram_we), int'(tbl[i].we));
         chk($sformatf("vec%0d busy", i), int'(bus.busy), int'(tbl[i].we));
         chk($sformatf("vec%0d overrun", i), int'(bus.overrun), int'(tbl[i].ov));
         chk($sformatf("vec%0d row", i), int'(bus.cursor_row), tbl[i].row);
         chk($sformatf("vec%0d col", i), int'(bus.cursor_col), tbl[i].col);
         if (tbl[i].we) begin
            chk($sformatf("vec%0d addr", i), int'(bus.ram_addr), tbl[i].addr);
            chk($sformatf("vec%0d wdata", i), int'(bus.ram_wdata), tbl[i].wd);
         end
      end

      // Grant withheld for five cycles; a byte arriving meanwhile is dropped.
      cyc(1, 8'h21, 0);
      chk("hold first we", int'(bus.ram_we), 1);
      for (int i = 0; i < 5; i++) begin
         cyc(i == 2, 8'h32, 0);
         chk($sformatf("hold%0d we", i), int'(bus.ram_we), 1);
         chk($sformatf("hold%0d addr", i), int'(bus.ram_addr), 82);
         chk($sformatf("hold%0d wdata", i), int'(bus.ram_wdata), 8'h63);
         chk($sformatf("hold%0d overrun", i), int'(bus.overrun), i == 2 ? 1 : 0);
      end
      cyc(0, 8'h00, 1);
      chk("hold commit we", int'(bus.ram_we), 0);
      chk("hold commit col", int'(bus.cursor_col), 3);
      cyc(0, 8'h00, 1);
      chk("dropped byte not written", int'(bus.ram_we), 0);
      check_model("hold");

      // Bottom-right corner write and wrap, then enter on the last row.
      for (int i = 0; i < ROWS && bus.cursor_row != 5'(ROWS - 1); i++) cyc(1, 8'h5A, 1);
      for (int i = 0; i < COLS - 1; i++) begin
         cyc(1, 8'h29, 1);
         cyc(0, 8'h00, 1);
      end
      check_model("corner pre");
      cyc(1, 8'h1C, 1);
      chk("corner addr", int'(bus.ram_addr), 2399);
      chk("corner wdata", int'(bus.ram_wdata), 8'h61);
      chk("corner we", int'(bus.ram_we), 1);
      cyc(0, 8'h00, 1);
      chk("corner wrap row", int'(bus.cursor_row), 0);
      chk("corner wrap col", int'(bus.cursor_col), 0);
      for (int i = 0; i < ROWS - 1; i++) cyc(1, 8'h5A, 1);
      chk("enter to last row", int'(bus.cursor_row), ROWS - 1);
      cyc(1, 8'h5A, 1);
      chk("enter wrap row", int'(bus.cursor_row), 0);
      chk("enter wrap col", int'(bus.cursor_col), 0);
      chk("enter no write", int'(bus.ram_we), 0);

      // Asynchronous reset while a write waits for grant.
      cyc(1, 8'h29, 1);
      cyc(0, 8'h00, 1);
      cyc(1, 8'h12, 1);
      cyc(1, 8'h1C, 0);
      chk("pre-reset we", int'(bus.ram_we), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset we", int'(bus.ram_we), 0);
      chk("async reset busy", int'(bus.busy), 0);
      chk("async reset col", int'(bus.cursor_col), 0);
      chk("async reset addr", int'(bus.ram_addr), 0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      cyc(1, 8'h1C, 1);
      chk("post-reset shift cleared", int'(bus.ram_wdata), 8'h61);
      chk("post-reset addr", int'(bus.ram_addr), 0);
      cyc(0, 8'h00, 1);
      check_model("post-reset");

      for (int i = 0; i < 4000; i++) begin
         logic [7:0] c;
         c = $urandom_range(0, 4) == 0 ? 8'($urandom) : pool[$urandom_range(0, 15)];
         cyc($urandom_range(0, 2) == 0, c, $urandom_range(0, 3) != 0);
         check_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
